// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port SRAM arbiter.
// Holds the response-owner encoding and the default starvation bound.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  localparam int unsigned DEFAULT_MAX_DATA_RUN = 4;
  localparam int unsigned RUN_CNT_W            = 4;

  // Saturating increment of the MEM run counter.
  function automatic logic [RUN_CNT_W-1:0] run_inc(
    input logic [RUN_CNT_W-1:0] cnt,
    input logic [RUN_CNT_W-1:0] limit
  );
    if (cnt < limit) begin
      return RUN_CNT_W'(cnt + 1'b1);
    end
    return limit;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_grant.sv
// Grant decision, MEM run counter and read-response ownership tracking.
// Grants are combinational; response owner and run count are registered.
module port_grant_ctrl
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic       mem_req,
  input  logic [3:0] mem_wen,
  output logic       grant_if,
  output logic       grant_mem,
  output logic [1:0] resp_owner
);

  localparam logic [RUN_CNT_W-1:0] MAX_RUN = RUN_CNT_W'(MAX_DATA_RUN);

  owner_e                 resp_owner_d, resp_owner_q;
  logic [RUN_CNT_W-1:0]   run_cnt_d, run_cnt_q;

  // Reset forces both grants low so the SRAM pins and stalls stay quiet.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (!reset) begin
      grant_mem = mem_req & (!if_req | (run_cnt_q < MAX_RUN));
      grant_if  = if_req & !grant_mem;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (grant_if) begin
      resp_owner_d = OWN_IF;
    end else if (grant_mem && (mem_wen == 4'b0000)) begin
      resp_owner_d = OWN_MEM;
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (grant_if || !if_req) begin
      run_cnt_d = '0;
    end else if (grant_mem) begin
      run_cnt_d = run_inc(run_cnt_q, MAX_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner_q <= OWN_NONE;
      run_cnt_q    <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  assign resp_owner = resp_owner_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and MEM-stage access.
// MEM has priority; a bounded run counter guarantees IF forward progress.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic       grant_if;
  logic       grant_mem;
  logic [1:0] resp_owner;

  port_grant_ctrl #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .grant_if  (grant_if),
    .grant_mem (grant_mem),
    .resp_owner(resp_owner)
  );

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_mem) begin
      sram_en    = 1'b1;
      sram_wen   = mem_wen;
      sram_addr  = mem_addr;
      sram_wdata = mem_wdata;
    end else if (grant_if) begin
      sram_en    = 1'b1;
      sram_addr  = if_addr;
    end
  end

  assign if_stall  = !reset & if_req  & !grant_if;
  assign mem_stall = !reset & mem_req & !grant_mem;

  // A read granted just before reset is dropped, so rvalid is masked by reset.
  assign if_rvalid  = !reset & (resp_owner == OWN_IF);
  assign mem_rvalid = !reset & (resp_owner == OWN_MEM);
  assign if_rdata   = sram_rdata;
  assign mem_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a scoreboard of read responses.
module tb_sram_port_arbiter;

  localparam int unsigned RUN      = 4;
  localparam logic [31:0] SRAM_KEY = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_stall, if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_DATA_RUN(RUN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_stall  (if_stall),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // SRAM model: a read returns an address-derived word one cycle later.
  always @(posedge clk) begin
    if (sram_en && sram_wen == 4'b0000) sram_rdata <= sram_addr ^ SRAM_KEY;
    else                                sram_rdata <= $urandom;
  end

  typedef struct {
    logic        is_if;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_run    = 0;
  logic        last_if_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic mreq, input logic [3:0] wen,
                      input logic [31:0] maddr, input logic [31:0] mdata);
    logic  gm, gi, en;
    resp_t e;
    reset     = rst;
    if_req    = ireq;
    if_addr   = iaddr;
    mem_req   = mreq;
    mem_wen   = wen;
    mem_addr  = maddr;
    mem_wdata = mdata;
    @(negedge clk);
    gm = !rst && mreq && (!ireq || m_run < RUN);
    gi = !rst && ireq && !gm;
    en = gm || gi;
    check_eq("if_stall",   32'(if_stall),  32'(!rst && ireq && !gi));
    check_eq("mem_stall",  32'(mem_stall), 32'(!rst && mreq && !gm));
    check_eq("sram_en",    32'(sram_en),   32'(en));
    check_eq("sram_addr",  sram_addr,      gm ? maddr : (gi ? iaddr : 32'h0));
    check_eq("sram_wen",   32'(sram_wen),  gm ? 32'(wen) : 32'h0);
    check_eq("sram_wdata", sram_wdata,     gm ? mdata : 32'h0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (rst) begin
        check_eq("drop_if_rvalid",  32'(if_rvalid),  32'h0);
        check_eq("drop_mem_rvalid", 32'(mem_rvalid), 32'h0);
      end else begin
        check_eq("if_rvalid",  32'(if_rvalid),  32'(e.is_if));
        check_eq("mem_rvalid", 32'(mem_rvalid), 32'(!e.is_if));
        check_eq(e.is_if ? "if_rdata" : "mem_rdata", e.is_if ? if_rdata : mem_rdata, e.data);
      end
    end else begin
      check_eq("idle_if_rvalid",  32'(if_rvalid),  32'h0);
      check_eq("idle_mem_rvalid", 32'(mem_rvalid), 32'h0);
    end
    if (gi)                       sb.push_back('{1'b1, iaddr ^ SRAM_KEY});
    else if (gm && wen == 4'b0000) sb.push_back('{1'b0, maddr ^ SRAM_KEY});
    last_if_gnt = ireq && !if_stall && !rst;
    if (rst || gi || !ireq) m_run = 0;
    else if (gm && m_run < RUN) m_run = m_run + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int n_if;
    // Reset with requests active: pins and stalls must stay low.
    step(1'b1, 1'b1, 32'hBFC0_0000, 1'b1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 32'hBFC0_0000, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
    idle();
    idle();
    // IF only, address held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();
    // Load/fetch collision; IF held until granted.
    step(1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 4'h0, 32'h8000_1000, 32'h0);
    check_eq("collide_if_stalled", 32'(last_if_gnt), 32'h0);
    step(1'b0, 1'b1, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("collide_if_granted", 32'(last_if_gnt), 32'h1);
    idle();
    // Store: no response follows.
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_2000, 32'h1234_5678);
    idle();
    // Starvation guard: IF wins exactly every fifth cycle.
    n_if = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 32'hBFC0_0020, 1'b1, 4'h0, 32'h8000_3000 + 32'(i) * 4, 32'h0);
      if (last_if_gnt) begin
        n_if++;
        check_eq("starve_slot", 32'(i % 5), 32'd4);
      end
    end
    check_eq("starve_if_count", 32'(n_if), 32'd4);
    idle();
    // Reset directly after an IF grant drops the response.
    step(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'hBFC0_0104, 1'b1, 4'h0, 32'h8000_4000, 32'h0);
    n_if = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'hBFC0_0104, 1'b1, 4'h0, 32'h8000_4000 + 32'(i) * 4, 32'h0);
      if (last_if_gnt) begin
        n_if++;
        check_eq("post_reset_slot", 32'(i), 32'd4);
      end
    end
    check_eq("post_reset_if_count", 32'(n_if), 32'd1);
    // Random traffic checked against the model.
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), $urandom, $urandom);
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port SRAM between instruction fetch (IF) and data access (MEM).
- Sits between the pc/IF logic, the MEM-stage load/store logic and the external SRAM pins. Per cycle it grants one requester, routes read data back one cycle later and raises a stall to whichever requester lost.
- MEM has priority because it is the older instruction. A run counter bounds IF starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, max consecutive MEM grants while IF is waiting (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_stall  out  1  fetch not granted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetched word
- mem_req  in  1  data request (load or store)
- mem_wen  in  4  byte write enables; 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_stall  out  1  data access not granted this cycle
- mem_rvalid  out  1  mem_rdata valid (loads only)
- mem_rdata  out  DATA_W  load data
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read with sram_en=1

Behaviour:
- Clocking: single clock `clk`. `reset` is synchronous and active-high.
- State registers:
  - resp_owner ∈ {NONE, IF, MEM}
  - run_cnt, 4 bits
- Grant is combinational in cycle T:
  - grant_mem = mem_req & (!if_req | run_cnt < MAX_DATA_RUN)
  - grant_if = if_req & !grant_mem
- SRAM drive:
  - grant_mem → sram_en=1, sram_wen=mem_wen, sram_addr=mem_addr, sram_wdata=mem_wdata
  - grant_if → sram_en=1, sram_wen=0, sram_addr=if_addr, sram_wdata=0
  - no grant → sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0
- Stalls: if_stall = if_req & !grant_if; mem_stall = mem_req & !grant_mem.
- A stalled requester holds req/addr/wdata stable until granted. The arbiter does not latch request payloads.
- resp_owner next value:
  - grant_if → IF
  - grant_mem & mem_wen==0 → MEM
  - otherwise (store or idle) → NONE
- Response in cycle T+1:
  - if_rvalid = (resp_owner==IF); mem_rvalid = (resp_owner==MEM)
  - if_rdata and mem_rdata both = sram_rdata. Consumers qualify with rvalid.
- Latency: read data is returned exactly 1 cycle after the grant. Back-to-back grants give full throughput.
- Stores produce no rvalid. A store completes in its grant cycle.
- run_cnt next value:
  - grant_if or !if_req → 0
  - grant_mem & if_req → run_cnt+1, saturating at MAX_DATA_RUN
- Starvation guard: when run_cnt==MAX_DATA_RUN and both request, IF wins. run_cnt then clears, so MEM wins next.
- Simultaneous requests with run_cnt<MAX_DATA_RUN: MEM granted, IF stalled.
- Reset behaviour:
  - While reset=1: grants forced 0, so all sram_* = 0 and both stalls = 0.
  - Next state: resp_owner=NONE, run_cnt=0, so both rvalids = 0 in the cycle after reset.
- Reset mid-operation: a read granted the cycle before reset asserts has its rvalid suppressed in the reset cycle. The response is dropped, not replayed.
- Outputs with no register (stalls, sram_*) follow their combinational equations. Registered state resets as above.

Decomposition:
- Shared package: owner encoding (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_MEM=2'd2) and the default MAX_DATA_RUN constant.
- Single module. The grant/run-counter logic may optionally split into sub-module `port_grant_ctrl`.

Test Plan:
- IF-only: if_req=1, if_addr=0xBFC00000 for 3 cycles, SRAM returns addr-derived data → sram_addr follows, if_stall=0, if_rvalid=1 on cycles 2–4 with matching data, mem_rvalid=0.
- Load/fetch collision: mem_req=1, wen=0, addr=0x80001000 and if_req=1 in the same cycle → sram_addr=0x80001000, if_stall=1, mem_stall=0; next cycle mem_rvalid=1 with the load data; IF then granted.
- Store: mem_req=1, wen=4'b0011, wdata=0x12345678 → sram_wen=4'b0011, sram_wdata=0x12345678 in the same cycle; no rvalid the following cycle.
- Starvation: mem_req and if_req held high with MAX_DATA_RUN=4 → MEM granted 4 cycles, IF 1 cycle, pattern repeats; if_stall low exactly every 5th cycle.
- Reset mid-read: IF granted at T, reset=1 at T+1 → if_rvalid=0 at T+1, all sram_* = 0 while reset is high, run_cnt=0 afterwards.
- Idle: no requests → sram_en=0, stalls=0, rvalids=0, run_cnt=0.
